// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction fetch owning the PC, next-PC select and the IF/ID pipeline register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic [1:0]  PCSrcE,
  input  logic [31:0] PCE,
  input  logic [31:0] ImmExtE,
  input  logic [31:0] ALUResultE,
  input  logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic [31:0] FetchCount,
  output logic        MisalignErr
);
  logic        redirect;
  logic        bubble;
  logic [31:0] target;
  always_comb begin
    redirect = PCSrcE == 2'b01 || PCSrcE == 2'b10;
    target   = PCSrcE == 2'b01 ? PCE + ImmExtE : {ALUResultE[31:1], 1'b0};
    bubble   = FlushD || redirect;
  end
  // A redirect squashes the wrong-path instruction in IF/ID even while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      PCF         <= RESET_PC;
      InstrD      <= NOP_INSTR;
      PCD         <= '0;
      PCPlus4D    <= '0;
      ValidD      <= 1'b0;
      FetchCount  <= '0;
      MisalignErr <= 1'b0;
    end else begin
      PCF <= redirect ? {target[31:2], 2'b00} : StallF ? PCF : PCF + 32'd4;
      if (redirect && target[1:0] != 2'b00) MisalignErr <= 1'b1;
      if (bubble) begin
        InstrD   <= NOP_INSTR;
        PCD      <= '0;
        PCPlus4D <= '0;
        ValidD   <= 1'b0;
      end else if (!StallD) begin
        InstrD     <= InstrF;
        PCD        <= PCF;
        PCPlus4D   <= PCF + 32'd4;
        ValidD     <= 1'b1;
        FetchCount <= FetchCount + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and random stimulus against a behavioural fetch model.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst, StallF, StallD, FlushD;
  logic [1:0]  PCSrcE;
  logic [31:0] PCE, ImmExtE, ALUResultE, InstrF;
  logic [31:0] PCF, InstrD, PCD, PCPlus4D, FetchCount;
  logic        ValidD, MisalignErr;
  int          passed = 0, total = 0;
  bit          check_en = 0;
  logic [31:0] m_pc, m_instr, m_pcd, m_pc4d, m_cnt;
  logic        m_valid, m_mis;
  logic [31:0] saved_cnt;

  fetch_stage dut (
    .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCE(PCE), .ImmExtE(ImmExtE), .ALUResultE(ALUResultE),
    .InstrF(InstrF), .PCF(PCF), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .ValidD(ValidD), .FetchCount(FetchCount), .MisalignErr(MisalignErr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]};
  endfunction

  assign InstrF = mem(PCF);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference: derive the next architectural state from the rules as plain arithmetic.
  always @(posedge clk) begin
    logic [31:0] tgt;
    logic        jump;
    jump = PCSrcE inside {2'd1, 2'd2};
    tgt  = (PCSrcE == 2'd1) ? PCE + ImmExtE : ALUResultE - (ALUResultE % 2);
    if (rst) begin
      m_pc = 32'h0; m_instr = 32'h13; m_pcd = 0; m_pc4d = 0; m_valid = 0; m_cnt = 0; m_mis = 0;
    end else begin
      if (jump && (tgt % 4) != 0) m_mis = 1;
      if (jump || FlushD) begin
        m_instr = 32'h13; m_pcd = 0; m_pc4d = 0; m_valid = 0;
      end else if (!StallD) begin
        m_instr = mem(m_pc); m_pcd = m_pc; m_pc4d = m_pc + 4; m_valid = 1; m_cnt = m_cnt + 1;
      end
      m_pc = jump ? tgt - (tgt % 4) : StallF ? m_pc : m_pc + 4;
    end
  end

  always @(negedge clk) if (check_en) begin
    check("PCF", PCF, m_pc);
    check("InstrD", InstrD, m_instr);
    check("PCD", PCD, m_pcd);
    check("PCPlus4D", PCPlus4D, m_pc4d);
    check("ValidD", {31'd0, ValidD}, {31'd0, m_valid});
    check("FetchCount", FetchCount, m_cnt);
    check("MisalignErr", {31'd0, MisalignErr}, {31'd0, m_mis});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect_jalr(input logic [31:0] a);
    PCSrcE = 2'd2; ALUResultE = a;
    tick();
    PCSrcE = 2'd0;
  endtask

  initial begin
    rst = 1; StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0; PCE = 0; ImmExtE = 0; ALUResultE = 0;
    tick();
    check_en = 1;
    tick();
    rst = 0;
    check("rst PCF", PCF, 32'h0);
    check("rst InstrD", InstrD, 32'h13);
    check("rst ValidD", {31'd0, ValidD}, 32'd0);
    check("rst FetchCount", FetchCount, 32'd0);
    repeat (3) tick();
    check("run PCF", PCF, 32'd12);
    check("run PCD", PCD, 32'd8);
    check("run FetchCount", FetchCount, 32'd3);
    check("run ValidD", {31'd0, ValidD}, 32'd1);
    PCSrcE = 2'd1; PCE = 32'h10; ImmExtE = 32'hFFFF_FFF0;
    tick();
    PCSrcE = 2'd0;
    check("br PCF", PCF, 32'h0);
    check("br ValidD", {31'd0, ValidD}, 32'd0);
    check("br InstrD", InstrD, 32'h13);
    check("br Misalign", {31'd0, MisalignErr}, 32'd0);
    tick();
    check("br target PCD", PCD, 32'h0);
    check("br target InstrD", InstrD, mem(32'h0));
    redirect_jalr(32'h107);
    check("jalr PCF", PCF, 32'h104);
    check("jalr Misalign", {31'd0, MisalignErr}, 32'd1);
    repeat (5) tick();
    check("jalr Misalign sticky", {31'd0, MisalignErr}, 32'd1);
    redirect_jalr(32'h1C);
    tick();
    StallF = 1; StallD = 1;
    saved_cnt = m_cnt;
    repeat (3) tick();
    check("stall PCF", PCF, 32'h20);
    check("stall PCD", PCD, 32'h1C);
    check("stall InstrD", InstrD, mem(32'h1C));
    check("stall FetchCount", FetchCount, saved_cnt);
    StallF = 0; StallD = 0;
    tick();
    check("release PCF", PCF, 32'h24);
    StallF = 1; StallD = 1; PCSrcE = 2'd1; PCE = 32'h40; ImmExtE = 32'h40;
    tick();
    check("prio PCF", PCF, 32'h80);
    check("prio ValidD", {31'd0, ValidD}, 32'd0);
    StallF = 0; StallD = 0; PCSrcE = 2'd0;
    tick();
    FlushD = 1; StallD = 1;
    tick();
    check("flush ValidD", {31'd0, ValidD}, 32'd0);
    FlushD = 0; StallD = 0;
    redirect_jalr(32'hFFFF_FFFC);
    tick();
    check("wrap PCF", PCF, 32'h0);
    check("wrap PCD", PCD, 32'hFFFF_FFFC);
    check("wrap PCPlus4D", PCPlus4D, 32'h0);
    PCSrcE = 2'd1; PCE = 32'h100; ImmExtE = 32'h3; rst = 1;
    tick();
    rst = 0; PCSrcE = 2'd0;
    check("midrst PCF", PCF, 32'h0);
    check("midrst ValidD", {31'd0, ValidD}, 32'd0);
    check("midrst FetchCount", FetchCount, 32'd0);
    check("midrst Misalign", {31'd0, MisalignErr}, 32'd0);
    check("midrst PCD", PCD, 32'd0);
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(63) == 0);
      StallF     = ($urandom_range(3) == 0);
      StallD     = ($urandom_range(3) == 0);
      FlushD     = ($urandom_range(7) == 0);
      PCSrcE     = ($urandom_range(3) == 0) ? 2'($urandom_range(3)) : 2'd0;
      PCE        = $urandom;
      ImmExtE    = ($urandom_range(1) == 0) ? 32'($urandom_range(255)) : $urandom;
      ALUResultE = $urandom;
      tick();
    end
    rst = 0; StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0;
    tick();
    @(negedge clk);
    #1;
    check_en = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
